// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types -- RAM word and status, arbiter states and grant encodings
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_I    = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;
   typedef enum logic [1:0] {IDLE = GRANT_NONE, IGRANT = GRANT_I, DGRANT = GRANT_D} arb_state_t;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter between instruction fetch and data access, data-first with starvation guard
//   CLK/RST                       clock, synchronous active-high reset
//   iREN/iaddr -> iload/iwait     instruction fetch port
//   dREN/dWEN/daddr/dstore -> dload/dwait   data port
//   ramREN/ramWEN/ramaddr/ramstore <- ramload/ramstate   RAM side
//   grant                         current owner (00 none, 01 instr, 10 data)
//   mem_err                       one-cycle pulse on RAM ERROR or read/write conflict
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       iREN,
   input  word_t      iaddr,
   output word_t      iload,
   output logic       iwait,
   input  logic       dREN,
   input  logic       dWEN,
   input  word_t      daddr,
   input  word_t      dstore,
   output word_t      dload,
   output logic       dwait,
   output logic       ramREN,
   output logic       ramWEN,
   output word_t      ramaddr,
   output word_t      ramstore,
   input  word_t      ramload,
   input  ramstate_t  ramstate,
   output logic [1:0] grant,
   output logic       mem_err
);
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
   arb_state_t state, next;
   logic [2:0] starve_cnt;
   logic       dreq, done, fin;
   always_comb begin
      dreq = dREN | dWEN;
      done = ramstate == ACCESS;
      fin  = done | (ramstate == ERROR);
      next = IDLE;
      case (state)
         IDLE: begin
            if (dreq && !(iREN && starve_cnt == LIMIT)) next = DGRANT;
            else if (iREN) next = IGRANT;
         end
         IGRANT: if (!fin && iREN) next = IGRANT;
         DGRANT: if (!fin && dreq) next = DGRANT;
         default: next = IDLE;
      endcase
   end
   // RAM side is a pure function of the registered owner; requesters hold their operands
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (state == IGRANT) begin
         ramREN  = 1'b1;
         ramaddr = iaddr;
      end else if (state == DGRANT) begin
         ramREN   = dREN & ~dWEN;
         ramWEN   = dWEN;
         ramaddr  = daddr;
         ramstore = dstore;
      end
      iwait = iREN & ~(state == IGRANT && done);
      dwait = dreq & ~(state == DGRANT && done);
      iload = ramload;
      dload = ramload;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         grant      <= GRANT_NONE;
         starve_cnt <= '0;
         mem_err    <= 1'b0;
      end else begin
         state   <= next;
         grant   <= next;
         // conflict flagged only on the edge that takes the data grant
         mem_err <= (state != IDLE && ramstate == ERROR) ||
                    (state == IDLE && next == DGRANT && dREN && dWEN);
         if (!iREN || (state == IGRANT && done)) starve_cnt <= '0;
         else if (state == DGRANT && done && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 3'd1;
      end
   end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive data grants after which a pending instruction request SHALL win the next arbitration.
REQ-002 CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset; synchronous and active-high.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 iload  out  32  fetched instruction.
REQ-007 iwait  out  1  high while the instruction request is unserviced.
REQ-008 dREN / dWEN  in  1 each  data read / write request.
REQ-009 daddr / dstore  in  32 each  data address / store data.
REQ-010 dload  out  32  loaded data.
REQ-011 dwait  out  1  high while the data request is unserviced.
REQ-012 ramREN / ramWEN  out  1 each  RAM read / write strobe.
REQ-013 ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-014 ramload  in  32  RAM read data.
REQ-015 ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-016 grant  out  2  current owner: 00 none, 01 instruction, 10 data.
REQ-017 mem_err  out  1  one-cycle pulse on a RAM ERROR or a dREN&dWEN conflict.

Function
REQ-018 The FSM SHALL have three states: IDLE, IGRANT and DGRANT.
REQ-019 IDLE: if a data request (dREN|dWEN) is present, the FSM SHALL go to DGRANT, unless iREN is high and starve_cnt==STARVE_LIMIT, in which case it SHALL go to IGRANT.
REQ-020 IDLE, iREN only: the FSM SHALL go to IGRANT; with no request it SHALL stay in IDLE.
REQ-021 The RAM strobes, ramaddr and ramstore SHALL be driven only from the registered state (IGRANT: ramREN=1, ramaddr=iaddr; DGRANT: ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore); in IDLE all strobes SHALL be 0.
REQ-022 Arbitration latency SHALL be exactly one cycle: a request first seen in IDLE in cycle N SHALL produce its strobe in cycle N+1.
REQ-023 In IGRANT, iwait SHALL be 0 and iload SHALL equal ramload combinationally in the cycle ramstate==ACCESS; the same rule SHALL apply to dwait/dload in DGRANT.
REQ-024 The waits SHALL be 1 in every other cycle while the matching request is asserted, and 0 when it is not asserted.
REQ-025 On ramstate==ACCESS the FSM SHALL return to IDLE in the next cycle, so there SHALL be one idle cycle between back-to-back grants.
REQ-026 Requesters SHALL hold address and data stable until their wait falls; the arbiter SHALL NOT latch them.
REQ-027 If the owner's request drops before ACCESS, the FSM SHALL return to IDLE in the next cycle and issue no further strobe.
REQ-028 On ramstate==ERROR in a grant state, the FSM SHALL pulse mem_err and return to IDLE; the owner's wait SHALL stay high so it retries.
REQ-029 If dREN and dWEN are both high, the request SHALL be treated as a write and mem_err SHALL pulse in the cycle the grant is taken.
REQ-030 starve_cnt (3 bits, saturating at STARVE_LIMIT) SHALL be incremented on each DGRANT completion while iREN is high, and SHALL clear on each IGRANT completion or whenever iREN is low.
REQ-031 grant SHALL be a registered copy of the state encoding.

Reset
REQ-032 While RST is high at a clock edge, state SHALL become IDLE, starve_cnt 0, grant 00 and mem_err 0.
REQ-033 Asserting RST mid-grant SHALL abort the access; strobes SHALL be 0 from the next cycle and no ACCESS completion SHALL be reported.

Structure
REQ-034 The ramstate_t enum and the word_t type SHALL come from cpu_types_pkg.
REQ-035 The arbiter state enum and the grant encodings SHALL be added to cpu_types_pkg.
REQ-036 The block SHALL be a single module with no sub-modules.

Verification
REQ-037 iREN=1, iaddr=0x40, RAM gives ACCESS on the 2nd strobe cycle -> iwait low exactly one cycle, iload=ramload, grant 01 then 00.
REQ-038 iREN and dREN rise together -> data is granted first (grant 10); the instruction is granted after one IDLE cycle.
REQ-039 dREN held continuously with iREN=1 -> after 4 data completions, grant=01 is the next grant.
REQ-040 dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dwait falls on ACCESS.
REQ-041 RST=1 during DGRANT with ramstate BUSY -> strobes 0 the next cycle, state IDLE, dwait stays 1.
REQ-042 ramstate=ERROR during IGRANT -> mem_err pulses one cycle, iwait stays 1, and the request is regranted.
